// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and the cacheline
// container used by the cache/memory buses.
package rv32i_types;

  localparam int LINE_W = 256;

  typedef logic [LINE_W-1:0] cacheline_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache in front of one memory
// port, with latched requests, registered outputs and a sticky timeout flag.
module mem_arbiter #(
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              err,
  output logic              last_grant_d
);
  import rv32i_types::*;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             i_req;
  logic             d_req;
  logic             grant_d;

  // On contention the side that did not win last time gets the port.
  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_d = d_req && (!i_req || !last_grant_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      err          <= 1'b0;
      last_grant_d <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            wait_cnt     <= '0;
            last_grant_d <= grant_d;
            if (grant_d) begin
              state     <= SERVE_D;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // A simultaneous read+write request is serviced as a writeback.
              mem_write <= d_write;
              mem_read  <= !d_write;
            end else begin
              state     <= SERVE_I;
              mem_addr  <= i_addr;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state == SERVE_I) begin
              i_rdata <= mem_rdata;
              i_resp  <= 1'b1;
            end else begin
              if (mem_read) d_rdata <= mem_rdata;
              d_resp <= 1'b1;
            end
          end else begin
            // Saturating wait counter; err latches once the limit is hit.
            if (wait_cnt != T_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt >= T_LAST) err <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for the single-cycle-visible
// behaviour plus hand sequences for latch stability, timeout and reset.
module tb_mem_arbiter;

  localparam int LW = 256;

  typedef struct packed {
    logic          rst;
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [31:0]   i_ad;
    logic [31:0]   d_ad;
    logic [LW-1:0] wd;
    logic          resp;
    logic [LW-1:0] rd;
    logic          e_mrd;
    logic          e_mwr;
    logic [31:0]   e_addr;
    logic [LW-1:0] e_wdata;
    logic [LW-1:0] e_irdata;
    logic [LW-1:0] e_drdata;
    logic          e_iresp;
    logic          e_dresp;
    logic          e_lg;
    logic          e_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          err;
  logic          last_grant_d;

  int vec_count  = 0;
  int fail_count = 0;

  logic [LW-1:0] d_ab;
  logic [LW-1:0] d_55;
  logic [LW-1:0] d_77;
  logic [LW-1:0] d_1234;
  logic [LW-1:0] z;

  vec_t tbl[$];

  mem_arbiter #(.LINE_W(LW), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .err          (err),
    .last_grant_d (last_grant_d)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic ir, input logic dr, input logic dw,
                              input logic [31:0] ia, input logic [31:0] da, input logic [LW-1:0] w,
                              input logic rs, input logic [LW-1:0] rdv,
                              input logic mrd, input logic mwr, input logic [31:0] ma,
                              input logic [LW-1:0] mwd, input logic [LW-1:0] ird, input logic [LW-1:0] drd,
                              input logic irs, input logic drs, input logic lg, input logic er);
    vec_t v;
    v.rst = r; v.i_rd = ir; v.d_rd = dr; v.d_wr = dw;
    v.i_ad = ia; v.d_ad = da; v.wd = w; v.resp = rs; v.rd = rdv;
    v.e_mrd = mrd; v.e_mwr = mwr; v.e_addr = ma; v.e_wdata = mwd;
    v.e_irdata = ird; v.e_drdata = drd; v.e_iresp = irs; v.e_dresp = drs;
    v.e_lg = lg; v.e_err = er;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic ir, input logic dr, input logic dw,
                               input logic [31:0] ia, input logic [31:0] da, input logic [LW-1:0] w,
                               input logic rs, input logic [LW-1:0] rdv);
    @(negedge clk);
    rst = r; i_read = ir; d_read = dr; d_write = dw;
    i_addr = ia; d_addr = da; d_wdata = w; mem_resp = rs; mem_rdata = rdv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vec_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    d_ab   = {32{8'hAB}};
    d_55   = {32{8'h55}};
    d_77   = {32{8'h77}};
    d_1234 = {16{16'h1234}};
    z      = '0;

    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_resp = 0; mem_rdata = 0;

    // rst i d w  i_addr d_addr wdata resp rdata | mrd mwr addr wdata i_rdata d_rdata iresp dresp lg err
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,   z,      0, z,    0,0, 32'h0,   z,      z,    z,    0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 32'h60,  32'h0,   z,      0, z,    1,0, 32'h60,  z,      z,    z,    0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h60,  32'h0,   z,      0, z,    1,0, 32'h60,  z,      z,    z,    0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h60,  32'h0,   z,      1, d_ab, 0,0, 32'h60,  z,      d_ab, z,    1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'h0,   z,      0, z,    0,0, 32'h60,  z,      d_ab, z,    0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 32'h0,   32'h0,   z,      0, z,    0,0, 32'h0,   z,      z,    z,    0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 32'h200, 32'h100, z,      0, z,    1,0, 32'h100, z,      z,    z,    0,0,1,0));
    tbl.push_back(mk(0,1,1,0, 32'h200, 32'h100, z,      1, d_55, 0,0, 32'h100, z,      z,    d_55, 0,1,1,0));
    tbl.push_back(mk(0,1,1,0, 32'h200, 32'h100, z,      0, z,    0,0, 32'h100, z,      z,    d_55, 0,0,1,0));
    tbl.push_back(mk(0,1,1,0, 32'h200, 32'h100, z,      0, z,    1,0, 32'h200, z,      z,    d_55, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h200, 32'h100, z,      1, d_77, 0,0, 32'h200, z,      d_77, d_55, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'h0,   z,      0, z,    0,0, 32'h200, z,      d_77, d_55, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 32'h0,   32'h80,  d_1234, 0, z,    0,1, 32'h80,  d_1234, d_77, d_55, 0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'h80,  z,      1, d_ab, 0,0, 32'h80,  d_1234, d_77, d_55, 0,1,1,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'h0,   z,      0, z,    0,0, 32'h80,  d_1234, d_77, d_55, 0,0,1,0));
    tbl.push_back(mk(0,0,1,1, 32'h0,   32'hA0,  d_77,   0, z,    0,1, 32'hA0,  d_77,   d_77, d_55, 0,0,1,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'hA0,  z,      1, d_ab, 0,0, 32'hA0,  d_77,   d_77, d_55, 0,1,1,0));
    tbl.push_back(mk(0,0,0,0, 32'h0,   32'h0,   z,      0, z,    0,0, 32'hA0,  d_77,   d_77, d_55, 0,0,1,0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].i_rd, tbl[i].d_rd, tbl[i].d_wr, tbl[i].i_ad,
                    tbl[i].d_ad, tbl[i].wd, tbl[i].resp, tbl[i].rd);
      checkOutput($sformatf("v%0d.mem_read", i),     LW'(mem_read),     LW'(tbl[i].e_mrd));
      checkOutput($sformatf("v%0d.mem_write", i),    LW'(mem_write),    LW'(tbl[i].e_mwr));
      checkOutput($sformatf("v%0d.mem_addr", i),     LW'(mem_addr),     LW'(tbl[i].e_addr));
      checkOutput($sformatf("v%0d.mem_wdata", i),    mem_wdata,         tbl[i].e_wdata);
      checkOutput($sformatf("v%0d.i_rdata", i),      i_rdata,           tbl[i].e_irdata);
      checkOutput($sformatf("v%0d.d_rdata", i),      d_rdata,           tbl[i].e_drdata);
      checkOutput($sformatf("v%0d.i_resp", i),       LW'(i_resp),       LW'(tbl[i].e_iresp));
      checkOutput($sformatf("v%0d.d_resp", i),       LW'(d_resp),       LW'(tbl[i].e_dresp));
      checkOutput($sformatf("v%0d.last_grant_d", i), LW'(last_grant_d), LW'(tbl[i].e_lg));
      checkOutput($sformatf("v%0d.err", i),          LW'(err),          LW'(tbl[i].e_err));
    end

    // Stable latch: d_addr moves while SERVE_D is outstanding.
    applyStimulus(0, 0, 1, 0, 32'h0, 32'hC0, z, 0, z);
    checkOutput("latch.grant_addr", LW'(mem_addr), LW'(32'hC0));
    checkOutput("latch.grant_read", LW'(mem_read), LW'(1'b1));
    applyStimulus(0, 0, 1, 0, 32'h0, 32'hE0, z, 0, z);
    checkOutput("latch.hold_addr", LW'(mem_addr), LW'(32'hC0));
    checkOutput("latch.hold_read", LW'(mem_read), LW'(1'b1));
    applyStimulus(0, 0, 0, 0, 32'h0, 32'hE0, z, 1, d_ab);
    checkOutput("latch.done_addr", LW'(mem_addr), LW'(32'hC0));
    checkOutput("latch.d_resp", LW'(d_resp), LW'(1'b1));
    checkOutput("latch.d_rdata", d_rdata, d_ab);
    checkOutput("latch.i_resp", LW'(i_resp), LW'(1'b0));
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 0, z);
    checkOutput("latch.idle_d_resp", LW'(d_resp), LW'(1'b0));

    // Timeout: memory withholds its response for 12 serve cycles.
    applyStimulus(0, 1, 0, 0, 32'h300, 32'h0, z, 0, z);
    checkOutput("tmo.grant_addr", LW'(mem_addr), LW'(32'h300));
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 0, z);
      checkOutput($sformatf("tmo.err_w%0d", k), LW'(err), LW'(k >= 8));
      checkOutput($sformatf("tmo.read_w%0d", k), LW'(mem_read), LW'(1'b1));
    end
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 1, d_55);
    checkOutput("tmo.i_resp", LW'(i_resp), LW'(1'b1));
    checkOutput("tmo.i_rdata", i_rdata, d_55);
    checkOutput("tmo.err_done", LW'(err), LW'(1'b1));
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 0, z);
    checkOutput("tmo.err_idle", LW'(err), LW'(1'b1));
    checkOutput("tmo.read_idle", LW'(mem_read), LW'(1'b0));

    // Reset mid-transaction, then fresh and back-to-back requests.
    applyStimulus(0, 1, 0, 0, 32'h400, 32'h0, z, 0, z);
    checkOutput("rst.serve_read", LW'(mem_read), LW'(1'b1));
    @(negedge clk);
    rst = 1'b1; i_read = 1'b0;
    #1;
    checkOutput("rst.async_read", LW'(mem_read), LW'(1'b0));
    checkOutput("rst.async_err", LW'(err), LW'(1'b0));
    checkOutput("rst.async_addr", LW'(mem_addr), LW'(32'h0));
    checkOutput("rst.async_irdata", i_rdata, z);
    checkOutput("rst.async_lg", LW'(last_grant_d), LW'(1'b0));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 1, d_ab);
      checkOutput($sformatf("rst.no_iresp%0d", k), LW'(i_resp), LW'(1'b0));
      checkOutput($sformatf("rst.no_read%0d", k), LW'(mem_read), LW'(1'b0));
    end
    applyStimulus(0, 1, 0, 0, 32'h500, 32'h0, z, 0, z);
    checkOutput("b2b.grant1_read", LW'(mem_read), LW'(1'b1));
    checkOutput("b2b.grant1_addr", LW'(mem_addr), LW'(32'h500));
    applyStimulus(0, 1, 0, 0, 32'h500, 32'h0, z, 1, d_ab);
    checkOutput("b2b.resp1", LW'(i_resp), LW'(1'b1));
    checkOutput("b2b.rdata1", i_rdata, d_ab);
    applyStimulus(0, 1, 0, 0, 32'h500, 32'h0, z, 0, z);
    checkOutput("b2b.idle_resp", LW'(i_resp), LW'(1'b0));
    checkOutput("b2b.idle_read", LW'(mem_read), LW'(1'b0));
    applyStimulus(0, 1, 0, 0, 32'h500, 32'h0, z, 0, z);
    checkOutput("b2b.grant2_read", LW'(mem_read), LW'(1'b1));
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 1, d_77);
    checkOutput("b2b.resp2", LW'(i_resp), LW'(1'b1));
    checkOutput("b2b.rdata2", i_rdata, d_77);
    checkOutput("b2b.no_dresp", LW'(d_resp), LW'(1'b0));
    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, z, 0, z);
    checkOutput("b2b.final_resp", LW'(i_resp), LW'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
